xbar_peri_arb: RTL

Two-master round-robin TileLink-UL arbiter for the 24 MHz peripheral domain. It shares the single peripheral slave port between two requesters, for example the CDC adapter and a local DMA engine. It accepts one Channel A request at a time and replays it to the slave from a holding register. It then steers the slave's Channel D response back to the winning master. Only one transaction is outstanding at any time.

---
 rtl/xbar_peri_arb_if.sv | 49 ++++
 rtl/xbar_peri_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xbar_peri_arb_if.sv
// xbar_peri_arb_if -- one TileLink-UL link (Channel A request, Channel D response).
//
// master modport : requester side, drives Channel A and d_ready
// slave modport  : responder side, drives Channel D and a_ready
//
// a_valid/a_ready, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data
// d_valid/d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
interface xbar_peri_arb_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3
) ();
  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [PARAM_WIDTH-1:0]  a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic                    a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic                    d_source;
  logic                    d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  d_ready
  );
endinterface

// File: rtl/xbar_peri_arb.sv
// xbar_peri_arb -- two-master round-robin TileLink-UL arbiter, 24 MHz peripheral domain.
// One Channel A request is accepted at a time, held in a register and replayed to
// the slave; the slave's Channel D response is steered back to the winning master.
//
// Ports:
//   clk    in  single clock
//   reset  in  synchronous, active-high
//   m0, m1 xbar_peri_arb_if.slave  upstream requesters
//   s      xbar_peri_arb_if.master downstream peripheral slave
//
// Optional feature: define XBAR_PERI_ARB_TIMEOUT_EN to add a response timeout
// (TIMEOUT_CYCLES) that answers the owner with an error AccessAck/AccessAckData.
module xbar_peri_arb #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned OPCODE_WIDTH   = 3,
  parameter int unsigned PARAM_WIDTH    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            reset,
  xbar_peri_arb_if.slave  m0,
  xbar_peri_arb_if.slave  m1,
  xbar_peri_arb_if.master s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
    , ST_ERR = 2'd3
`endif
  } state_t;

  state_t                  state_q;
  logic                    prio_q;
  logic                    owner_q;

  logic [OPCODE_WIDTH-1:0] hold_opcode_q;
  logic [PARAM_WIDTH-1:0]  hold_param_q;
  logic [SIZE_WIDTH-1:0]   hold_size_q;
  logic                    hold_source_q;
  logic [ADDR_WIDTH-1:0]   hold_address_q;
  logic [MASK_WIDTH-1:0]   hold_mask_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;

`ifdef XBAR_PERI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [OPCODE_WIDTH-1:0] OP_GET            = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK_DAT = OPCODE_WIDTH'(1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // Grant: master 0 wins unless master 1 holds priority and is also requesting.
  logic gnt0, gnt1;
  assign gnt0 = (state_q == ST_IDLE) && m0.a_valid && (!prio_q || !m1.a_valid);
  assign gnt1 = (state_q == ST_IDLE) && m1.a_valid && !gnt0;

  assign m0.a_ready = gnt0;
  assign m1.a_ready = gnt1;

  // Slave Channel A replays the holding register.
  assign s.a_valid   = (state_q == ST_REQ);
  assign s.a_opcode  = hold_opcode_q;
  assign s.a_param   = hold_param_q;
  assign s.a_size    = hold_size_q;
  assign s.a_source  = hold_source_q;
  assign s.a_address = hold_address_q;
  assign s.a_mask    = hold_mask_q;
  assign s.a_data    = hold_data_q;

  // Channel D: one shared response bus, valid gated per owner.
  logic                    d_valid_w;
  logic [OPCODE_WIDTH-1:0] d_opcode_w;
  logic [PARAM_WIDTH-1:0]  d_param_w;
  logic [SIZE_WIDTH-1:0]   d_size_w;
  logic                    d_source_w;
  logic                    d_sink_w;
  logic [DATA_WIDTH-1:0]   d_data_w;
  logic                    d_error_w;
  logic                    s_d_ready_w;
  logic                    own_d_ready;
  logic                    d_hs;

  assign own_d_ready = owner_q ? m1.d_ready : m0.d_ready;

  always_comb begin
    d_valid_w   = 1'b0;
    d_opcode_w  = s.d_opcode;
    d_param_w   = s.d_param;
    d_size_w    = s.d_size;
    d_source_w  = s.d_source;
    d_sink_w    = s.d_sink;
    d_data_w    = s.d_data;
    d_error_w   = s.d_error;
    s_d_ready_w = 1'b0;
    unique case (state_q)
      // Stray slave beats in IDLE are swallowed, never forwarded.
      ST_IDLE: s_d_ready_w = 1'b1;
      ST_RESP: begin
        d_valid_w   = s.d_valid;
        s_d_ready_w = own_d_ready;
      end
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
      ST_ERR: begin
        d_valid_w  = 1'b1;
        d_opcode_w = (hold_opcode_q == OP_GET) ? OP_ACCESS_ACK_DAT : OP_ACCESS_ACK;
        d_param_w  = '0;
        d_size_w   = hold_size_q;
        d_source_w = hold_source_q;
        d_sink_w   = 1'b0;
        d_data_w   = '0;
        d_error_w  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign d_hs      = d_valid_w && own_d_ready;
  assign s.d_ready = s_d_ready_w;

  assign m0.d_valid  = d_valid_w && !owner_q;
  assign m0.d_opcode = d_opcode_w;
  assign m0.d_param  = d_param_w;
  assign m0.d_size   = d_size_w;
  assign m0.d_source = d_source_w;
  assign m0.d_sink   = d_sink_w;
  assign m0.d_data   = d_data_w;
  assign m0.d_error  = d_error_w;

  assign m1.d_valid  = d_valid_w && owner_q;
  assign m1.d_opcode = d_opcode_w;
  assign m1.d_param  = d_param_w;
  assign m1.d_size   = d_size_w;
  assign m1.d_source = d_source_w;
  assign m1.d_sink   = d_sink_w;
  assign m1.d_data   = d_data_w;
  assign m1.d_error  = d_error_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      hold_opcode_q  <= '0;
      hold_param_q   <= '0;
      hold_size_q    <= '0;
      hold_source_q  <= 1'b0;
      hold_address_q <= '0;
      hold_mask_q    <= '0;
      hold_data_q    <= '0;
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            hold_opcode_q  <= gnt1 ? m1.a_opcode  : m0.a_opcode;
            hold_param_q   <= gnt1 ? m1.a_param   : m0.a_param;
            hold_size_q    <= gnt1 ? m1.a_size    : m0.a_size;
            hold_source_q  <= gnt1 ? m1.a_source  : m0.a_source;
            hold_address_q <= gnt1 ? m1.a_address : m0.a_address;
            hold_mask_q    <= gnt1 ? m1.a_mask    : m0.a_mask;
            hold_data_q    <= gnt1 ? m1.a_data    : m0.a_data;
            owner_q        <= gnt1;
            state_q        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s.a_ready) begin
            state_q <= ST_RESP;
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_RESP: begin
          if (d_hs) begin
            prio_q  <= !owner_q;
            state_q <= ST_IDLE;
          end
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
          // Counts only cycles with no slave response offered; the cycle
          // that would bring the count to TIMEOUT_CYCLES moves to ERR.
          else if (!s.d_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_q <= ST_ERR;
            else                                      cnt_q   <= cnt_q + 1'b1;
          end
`endif
        end
`ifdef XBAR_PERI_ARB_TIMEOUT_EN
        ST_ERR: begin
          if (d_hs) begin
            prio_q  <= !owner_q;
            state_q <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
